// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/WB with a sticky illegal flag and a retire counter.
// Strobes are decoded from the state; ir_we also depends on imem_ready. Reset is synchronous, active-high.
module cpu_sequencer #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                halt_req,
  input  logic                imem_ready,
  input  logic [31:0]         instr,
  output logic                ir_we,
  output logic                rf_en,
  output logic                rf_we,
  output logic                pc_we,
  output logic [1:0]          alu_func,
  output logic                busy,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          alu_func_q, alu_func_d;
  logic                illegal_q, illegal_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic       dec_ok;
  logic [1:0] dec_func;

  // Only the opcode and funct fields take part in decoding.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  always_comb begin
    dec_ok   = 1'b0;
    dec_func = 2'b00;
    if (instr[31:26] == 6'd0) begin
      case (instr[5:0])
        6'h20: begin dec_ok = 1'b1; dec_func = 2'b00; end
        6'h22: begin dec_ok = 1'b1; dec_func = 2'b01; end
        6'h24: begin dec_ok = 1'b1; dec_func = 2'b10; end
        6'h25: begin dec_ok = 1'b1; dec_func = 2'b11; end
        default: begin dec_ok = 1'b0; dec_func = 2'b00; end
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_func_d = alu_func_q;
    illegal_d  = illegal_q;
    retired_d  = retired_q;
    ir_we      = 1'b0;
    rf_en      = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_ok) begin
          alu_func_d = dec_func;
          state_d    = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        rf_en   = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
        state_d   = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      alu_func_q <= 2'b00;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      alu_func_q <= alu_func_d;
      illegal_q  <= illegal_d;
      retired_q  <= retired_d;
    end
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign alu_func = alu_func_q;
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: per-cycle expected strobes and retire counts are queued with the stimulus.
// Two instances share inputs: default RETIRE_W and RETIRE_W=4 for the wrap scenario.
module tb_cpu_sequencer;

  localparam logic [31:0] I_ADD = 32'h00221820;
  localparam logic [31:0] I_SUB = 32'h00221822;
  localparam logic [31:0] I_AND = 32'h00221824;
  localparam logic [31:0] I_OR  = 32'h00221825;
  localparam logic [31:0] I_LW  = 32'h8C220000;

  // Expected {ir_we, rf_en, rf_we, pc_we, busy} per state.
  localparam logic [4:0] V_IDLE  = 5'b00000;
  localparam logic [4:0] V_FETCH = 5'b00001;
  localparam logic [4:0] V_FRDY  = 5'b10001;
  localparam logic [4:0] V_DEC   = 5'b00001;
  localparam logic [4:0] V_EXEC  = 5'b01001;
  localparam logic [4:0] V_WB    = 5'b00111;
  localparam logic [4:0] V_HALT  = 5'b00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        halt_req = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] instr = 32'd0;

  logic        ir_we_a, rf_en_a, rf_we_a, pc_we_a, busy_a, illegal_a;
  logic [1:0]  alu_a;
  logic [31:0] retired_a;
  logic        ir_we_b, rf_en_b, rf_we_b, pc_we_b, busy_b, illegal_b;
  logic [1:0]  alu_b;
  logic [3:0]  retired_b;

  cpu_sequencer dut_a (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .imem_ready(imem_ready),
    .instr(instr), .ir_we(ir_we_a), .rf_en(rf_en_a), .rf_we(rf_we_a), .pc_we(pc_we_a),
    .alu_func(alu_a), .busy(busy_a), .illegal(illegal_a), .retired(retired_a)
  );

  cpu_sequencer #(.RETIRE_W(4)) dut_b (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .imem_ready(imem_ready),
    .instr(instr), .ir_we(ir_we_b), .rf_en(rf_en_b), .rf_we(rf_we_b), .pc_we(pc_we_b),
    .alu_func(alu_b), .busy(busy_b), .illegal(illegal_b), .retired(retired_b)
  );

  always #5 clk = ~clk;

  logic [4:0] obs_a, obs_b;
  assign obs_a = {ir_we_a, rf_en_a, rf_we_a, pc_we_a, busy_a};
  assign obs_b = {ir_we_b, rf_en_b, rf_we_b, pc_we_b, busy_b};

  typedef struct {
    logic        run;
    logic        halt;
    logic        rdy;
    logic        rst;
    logic [31:0] instr;
    logic        chk;
    logic [4:0]  exp;
    logic [31:0] ret;
  } cyc_t;

  cyc_t        sb_q[$];
  logic [31:0] model_ret = 32'd0;
  int          checks = 0;
  int          errors = 0;

  // Queue one cycle of stimulus with the outputs expected during it; the
  // retire count advances on every expected WB not overridden by reset.
  function automatic void push(logic r, logic h, logic y, logic s, logic [31:0] i,
                               logic chk, logic [4:0] e);
    cyc_t c;
    c.run = r; c.halt = h; c.rdy = y; c.rst = s; c.instr = i;
    c.chk = chk; c.exp = e; c.ret = model_ret;
    sb_q.push_back(c);
    if (s) model_ret = 32'd0;
    else if (chk && e == V_WB) model_ret = model_ret + 32'd1;
  endfunction

  task automatic apply(input cyc_t c);
    run        = c.run;
    halt_req   = c.halt;
    imem_ready = c.rdy;
    rst        = c.rst;
    instr      = c.instr;
  endtask

  task automatic test_reset();
    cyc_t c;
    int   step = 0;
    push(1, 1, 1, 1, I_OR, 0, V_IDLE);
    push(1, 1, 1, 1, I_OR, 1, V_IDLE);
    push(0, 0, 0, 0, I_OR, 1, V_IDLE);
    push(0, 0, 0, 0, I_OR, 1, V_IDLE);
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      @(negedge clk); apply(c); #1;
      if (c.chk) begin
        checks++;
        if ({obs_a, obs_b} !== {c.exp, c.exp}) begin
          errors++; $display("FAIL reset step%0d strobes got %b/%b want %b", step, obs_a, obs_b, c.exp);
        end
        checks++;
        if ({retired_a, retired_b} !== {c.ret, c.ret[3:0]}) begin
          errors++; $display("FAIL reset step%0d retired got %0d/%0d want %0d", step, retired_a, retired_b, c.ret);
        end
      end
      step++;
    end
    checks++;
    if ({alu_a, illegal_a, alu_b, illegal_b} !== 6'd0) begin
      errors++; $display("FAIL reset_regs alu/illegal got %b %b want 00 0", alu_a, illegal_a);
    end
  endtask

  task automatic test_basic_add();
    cyc_t c;
    int   step = 0;
    push(0, 0, 0, 1, I_SUB, 0, V_IDLE);
    push(1, 0, 1, 0, I_ADD, 1, V_IDLE);
    push(0, 0, 1, 0, I_ADD, 1, V_FRDY);
    push(0, 0, 1, 0, I_ADD, 1, V_DEC);
    push(0, 0, 1, 0, I_ADD, 1, V_EXEC);
    push(0, 1, 1, 0, I_ADD, 1, V_WB);
    push(1, 0, 1, 0, I_ADD, 1, V_HALT);
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      @(negedge clk); apply(c); #1;
      if (c.chk) begin
        checks++;
        if ({obs_a, obs_b} !== {c.exp, c.exp}) begin
          errors++; $display("FAIL add step%0d strobes got %b/%b want %b", step, obs_a, obs_b, c.exp);
        end
        checks++;
        if ({retired_a, retired_b} !== {c.ret, c.ret[3:0]}) begin
          errors++; $display("FAIL add step%0d retired got %0d/%0d want %0d", step, retired_a, retired_b, c.ret);
        end
      end
      step++;
    end
    checks++;
    if (alu_a !== 2'b00 || illegal_a !== 1'b0 || retired_a !== 32'd1) begin
      errors++; $display("FAIL add_final alu=%b ill=%b ret=%0d want 00 0 1", alu_a, illegal_a, retired_a);
    end
  endtask

  task automatic test_fetch_stall();
    cyc_t c;
    int   step = 0;
    push(0, 0, 0, 1, I_AND, 0, V_IDLE);
    push(1, 0, 0, 0, I_AND, 1, V_IDLE);
    for (int k = 0; k < 3; k++) push(0, 0, 0, 0, I_AND, 1, V_FETCH);
    push(0, 0, 1, 0, I_AND, 1, V_FRDY);
    push(0, 0, 0, 0, I_AND, 1, V_DEC);
    push(0, 0, 0, 0, I_AND, 1, V_EXEC);
    push(0, 1, 0, 0, I_AND, 1, V_WB);
    push(0, 0, 0, 0, I_AND, 1, V_HALT);
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      @(negedge clk); apply(c); #1;
      if (c.chk) begin
        checks++;
        if ({obs_a, obs_b} !== {c.exp, c.exp}) begin
          errors++; $display("FAIL stall step%0d strobes got %b/%b want %b", step, obs_a, obs_b, c.exp);
        end
        checks++;
        if ({retired_a, retired_b} !== {c.ret, c.ret[3:0]}) begin
          errors++; $display("FAIL stall step%0d retired got %0d/%0d want %0d", step, retired_a, retired_b, c.ret);
        end
      end
      step++;
    end
    checks++;
    if (alu_a !== 2'b10 || retired_a !== 32'd1) begin
      errors++; $display("FAIL stall_final alu=%b ret=%0d want 10 1", alu_a, retired_a);
    end
  endtask

  task automatic test_illegal();
    cyc_t c;
    int   step = 0;
    push(0, 0, 0, 1, I_OR, 0, V_IDLE);
    push(1, 0, 1, 0, I_OR, 1, V_IDLE);
    push(0, 0, 1, 0, I_OR, 1, V_FRDY);
    push(0, 0, 1, 0, I_OR, 1, V_DEC);
    push(0, 0, 1, 0, I_OR, 1, V_EXEC);
    push(0, 0, 1, 0, I_OR, 1, V_WB);
    push(0, 0, 1, 0, I_LW, 1, V_FRDY);
    push(0, 0, 1, 0, I_LW, 1, V_DEC);
    push(1, 1, 1, 0, I_ADD, 1, V_HALT);
    push(1, 1, 1, 0, I_ADD, 1, V_HALT);
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      @(negedge clk); apply(c); #1;
      if (c.chk) begin
        checks++;
        if ({obs_a, obs_b} !== {c.exp, c.exp}) begin
          errors++; $display("FAIL illegal step%0d strobes got %b/%b want %b", step, obs_a, obs_b, c.exp);
        end
        checks++;
        if ({retired_a, retired_b} !== {c.ret, c.ret[3:0]}) begin
          errors++; $display("FAIL illegal step%0d retired got %0d/%0d want %0d", step, retired_a, retired_b, c.ret);
        end
      end
      step++;
    end
    checks++;
    if (illegal_a !== 1'b1 || illegal_b !== 1'b1 || alu_a !== 2'b11 || busy_a !== 1'b0) begin
      errors++; $display("FAIL illegal_final ill=%b alu=%b busy=%b want 1 11 0", illegal_a, alu_a, busy_a);
    end
  endtask

  task automatic test_halt_req();
    cyc_t c;
    int   step = 0;
    push(0, 0, 0, 1, I_ADD, 0, V_IDLE);
    push(1, 1, 1, 0, I_SUB, 1, V_IDLE);
    push(0, 1, 1, 0, I_SUB, 1, V_FRDY);
    push(0, 1, 1, 0, I_SUB, 1, V_DEC);
    push(0, 1, 1, 0, I_SUB, 1, V_EXEC);
    push(0, 1, 1, 0, I_SUB, 1, V_WB);
    push(1, 0, 1, 0, I_SUB, 1, V_HALT);
    push(1, 0, 1, 0, I_SUB, 1, V_HALT);
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      @(negedge clk); apply(c); #1;
      if (c.chk) begin
        checks++;
        if ({obs_a, obs_b} !== {c.exp, c.exp}) begin
          errors++; $display("FAIL halt step%0d strobes got %b/%b want %b", step, obs_a, obs_b, c.exp);
        end
        checks++;
        if ({retired_a, retired_b} !== {c.ret, c.ret[3:0]}) begin
          errors++; $display("FAIL halt step%0d retired got %0d/%0d want %0d", step, retired_a, retired_b, c.ret);
        end
      end
      step++;
    end
    checks++;
    if (alu_a !== 2'b01 || retired_a !== 32'd1) begin
      errors++; $display("FAIL halt_final alu=%b ret=%0d want 01 1", alu_a, retired_a);
    end
  endtask

  task automatic test_reset_mid();
    cyc_t c;
    int   step = 0;
    // Reset while in EXEC.
    push(0, 0, 0, 1, I_AND, 0, V_IDLE);
    push(1, 0, 1, 0, I_AND, 1, V_IDLE);
    push(0, 0, 1, 0, I_AND, 1, V_FRDY);
    push(0, 0, 1, 0, I_AND, 1, V_DEC);
    push(1, 0, 1, 1, I_AND, 1, V_EXEC);
    push(0, 0, 1, 0, I_AND, 1, V_IDLE);
    // Reset while in WB, after alu_func has been loaded again.
    push(1, 0, 1, 0, I_AND, 1, V_IDLE);
    push(0, 0, 1, 0, I_AND, 1, V_FRDY);
    push(0, 0, 1, 0, I_AND, 1, V_DEC);
    push(0, 0, 1, 0, I_AND, 1, V_EXEC);
    push(0, 1, 1, 1, I_AND, 0, V_WB);
    push(0, 0, 1, 0, I_AND, 1, V_IDLE);
    push(0, 0, 1, 0, I_AND, 1, V_IDLE);
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      @(negedge clk); apply(c); #1;
      if (c.chk) begin
        checks++;
        if ({obs_a, obs_b} !== {c.exp, c.exp}) begin
          errors++; $display("FAIL rstmid step%0d strobes got %b/%b want %b", step, obs_a, obs_b, c.exp);
        end
        checks++;
        if ({retired_a, retired_b} !== {c.ret, c.ret[3:0]}) begin
          errors++; $display("FAIL rstmid step%0d retired got %0d/%0d want %0d", step, retired_a, retired_b, c.ret);
        end
      end
      step++;
    end
    checks++;
    if (alu_a !== 2'b00 || illegal_a !== 1'b0 || retired_a !== 32'd0) begin
      errors++; $display("FAIL rstmid_final alu=%b ill=%b ret=%0d want 00 0 0", alu_a, illegal_a, retired_a);
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c;
    int   step = 0;
    push(0, 0, 0, 1, I_OR, 0, V_IDLE);
    push(1, 0, 1, 0, I_OR, 1, V_IDLE);
    for (int k = 0; k < 16; k++) begin
      push(0, 0, 1, 0, I_OR, 1, V_FRDY);
      push(0, 0, 1, 0, I_OR, 1, V_DEC);
      push(0, 0, 1, 0, I_OR, 1, V_EXEC);
      push(0, (k == 15), 1, 0, I_OR, 1, V_WB);
    end
    push(0, 0, 1, 0, I_OR, 1, V_HALT);
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      @(negedge clk); apply(c); #1;
      if (c.chk) begin
        checks++;
        if ({obs_a, obs_b} !== {c.exp, c.exp}) begin
          errors++; $display("FAIL b2b step%0d strobes got %b/%b want %b", step, obs_a, obs_b, c.exp);
        end
        checks++;
        if ({retired_a, retired_b} !== {c.ret, c.ret[3:0]}) begin
          errors++; $display("FAIL b2b step%0d retired got %0d/%0d want %0d", step, retired_a, retired_b, c.ret);
        end
      end
      step++;
    end
    checks++;
    if (retired_b !== 4'd0 || retired_a !== 32'd16 || alu_b !== 2'b11) begin
      errors++; $display("FAIL wrap_final ret4=%0d ret32=%0d alu=%b want 0 16 11", retired_b, retired_a, alu_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_fetch_stall();
    test_illegal();
    test_halt_req();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
